// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - MD5 round constants, state type and message helpers
package md5_pkg;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S_TABLE [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  // Only i mod 16 matters, so 4-bit arithmetic gives the RFC index directly.
  function automatic logic [3:0] g_idx(input logic [5:0] i);
    logic [3:0] r;
    r = i[3:0];
    case (i[5:4])
      2'd0:    return r;
      2'd1:    return r * 4'd5 + 4'd1;
      2'd2:    return r * 4'd3 + 4'd5;
      default: return r * 4'd7;
    endcase
  endfunction

  // Padded single-block message for a fixed 8-byte input.
  function automatic logic [31:0] msg_word(input logic [63:0] txt, input logic [3:0] g);
    case (g)
      4'd0:    return {txt[39:32], txt[47:40], txt[55:48], txt[63:56]};
      4'd1:    return {txt[7:0], txt[15:8], txt[23:16], txt[31:24]};
      4'd2:    return 32'h00000080;
      4'd14:   return 32'h00000040;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/md5_round_step.sv
// rtl/md5_round_step.sv - one combinational MD5 round
module md5_round_step
  import md5_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] m_i,
  input  logic [5:0]  i_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [63:0] rot2;

  always_comb begin
    f = 32'h0;
    case (i_i[5:4])
      2'd0:    f = (b_i & c_i) | (~b_i & d_i);
      2'd1:    f = (d_i & b_i) | (~d_i & c_i);
      2'd2:    f = b_i ^ c_i ^ d_i;
      default: f = c_i ^ (b_i | ~d_i);
    endcase
    sum  = a_i + f + K_TABLE[i_i] + m_i;
    // Upper half of the doubled word shifted left is the 32-bit rotate.
    rot2 = {sum, sum} << S_TABLE[i_i];
    a_o  = d_i;
    b_o  = b_i + rot2[63:32];
    c_o  = b_i;
    d_o  = c_i;
  end

endmodule

// File: rtl/md5_round_engine.sv
// rtl/md5_round_engine.sv - iterative single-block MD5 engine for 8-char candidates
// Optional MD5_ROUND2X_EN: two chained rounds per clock (33-cycle latency).
module md5_round_engine
  import md5_pkg::*;
#(
  parameter int NROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in,
  input  logic [63:0]  txt,
  output logic         busy,
  output logic         valid,
  output logic [127:0] hash
);

`ifdef MD5_ROUND2X_EN
  localparam int RPE = 2;
`else
  localparam int RPE = 1;
`endif
  localparam logic [5:0] LAST_ROUND = 6'(NROUNDS - RPE);
  localparam logic [5:0] ROUND_INC  = 6'(RPE);

  state_e       state_q, state_d;
  logic [5:0]   round_q, round_d;
  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [31:0]  a_d, b_d, c_d, d_d;
  logic [63:0]  txt_q, txt_d;
  logic [127:0] hash_q, hash_d;
  logic         valid_q, valid_d;

  logic [31:0]  m0;
  logic [31:0]  a1, b1, c1, d1;
  logic [31:0]  step_a, step_b, step_c, step_d;

  assign m0 = msg_word(txt_q, g_idx(round_q));

  md5_round_step u_step0 (
    .a_i (a_q), .b_i (b_q), .c_i (c_q), .d_i (d_q),
    .m_i (m0),  .i_i (round_q),
    .a_o (a1),  .b_o (b1),  .c_o (c1),  .d_o (d1)
  );

`ifdef MD5_ROUND2X_EN
  logic [5:0]  round1;
  logic [31:0] m1;
  logic [31:0] a2, b2, c2, d2;

  assign round1 = round_q + 6'd1;
  assign m1     = msg_word(txt_q, g_idx(round1));

  md5_round_step u_step1 (
    .a_i (a1), .b_i (b1), .c_i (c1), .d_i (d1),
    .m_i (m1), .i_i (round1),
    .a_o (a2), .b_o (b2), .c_o (c2), .d_o (d2)
  );

  assign step_a = a2;
  assign step_b = b2;
  assign step_c = c2;
  assign step_d = d2;
`else
  assign step_a = a1;
  assign step_b = b1;
  assign step_c = c1;
  assign step_d = d1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      txt_q   <= '0;
      hash_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      txt_q   <= txt_d;
      hash_q  <= hash_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in) state_d = ROUND;
      ROUND:   if (round_q == LAST_ROUND) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    round_d = round_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    txt_d   = txt_q;
    hash_d  = hash_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (in) begin
          txt_d   = txt;
          round_d = '0;
          a_d     = IV_A;
          b_d     = IV_B;
          c_d     = IV_C;
          d_d     = IV_D;
          valid_d = 1'b0;
        end
      end
      ROUND: begin
        a_d     = step_a;
        b_d     = step_b;
        c_d     = step_c;
        d_d     = step_d;
        round_d = round_q + ROUND_INC;
      end
      FINAL: begin
        hash_d  = {bswap32(a_q + IV_A), bswap32(b_q + IV_B),
                   bswap32(c_q + IV_C), bswap32(d_q + IV_D)};
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    valid = valid_q;
    hash  = hash_q;
  end

endmodule
